// File: rtl/ag_vram_pkg.sv
// Shared types and helpers for the Agat video RAM burst engine.
// Optional feature macro: AG_VRAM_COLLISION_BYPASS_EN (see ag_vram_burst.sv).
package ag_vram_pkg;

  // Burst fetch engine states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fsm_state_t;

  // Source currently presented on the CPU read-data output
  typedef enum logic [1:0] {
    CDO_ZERO  = 2'd0,
    CDO_WDATA = 2'd1,
    CDO_RDATA = 2'd2
  } cdo_src_t;

  // Ceiling log2, usable in constant expressions
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Bit offset of a byte lane inside a video word: lane 0 is the most significant byte
  function automatic int lane_offset(input int lane, input int vbytes);
    return 8 * (vbytes - 1 - lane);
  endfunction

endpackage

// File: rtl/ag_sync_fifo.sv
// Small synchronous FIFO with occupancy count and synchronous flush.
// Head data is presented combinationally from the storage array.
module ag_sync_fifo
  import ag_vram_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int PTR_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1,
  localparam int CNT_W = clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             PUSH,
  input  logic [WIDTH-1:0] PUSH_DATA,
  input  logic             POP,
  output logic [WIDTH-1:0] POP_DATA,
  output logic             EMPTY,
  output logic [CNT_W-1:0] COUNT
);

  logic [WIDTH-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  assign EMPTY    = (count_reg == '0);
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign pop_ok   = POP && !EMPTY;
  assign push_ok  = PUSH && (!full || pop_ok);
  assign POP_DATA = fifo_mem[rd_ptr_reg];
  assign COUNT    = count_reg;

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointers and count; flush empties the queue in one cycle
  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
    end
  end

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge CLK) begin
    if (push_ok) fifo_mem[wr_ptr_reg] <= PUSH_DATA;
  end

endmodule

// File: rtl/ag_vram_burst.sv
// Agat dual-port CPU/video RAM with a video burst fetch engine.
// CPU side is a byte port; video side streams consecutive words into a FIFO.
// Optional macro AG_VRAM_COLLISION_BYPASS_EN: when defined, a video read that
// collides with a CPU write to the same word returns the merged new word;
// otherwise the video read sees the old word (read-first).
module ag_vram_burst
  import ag_vram_pkg::*;
#(
  parameter int ADDR_W     = 15,
  parameter int VBYTES     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 7,
  localparam int VA_W      = ADDR_W - clog2(VBYTES),
  localparam int DW        = 8 * VBYTES
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              C_CS,
  input  logic              C_WE,
  input  logic [ADDR_W-1:0] C_ADDR,
  input  logic [7:0]        C_DI,
  output logic [7:0]        C_DO,
  input  logic              V_START,
  input  logic [VA_W-1:0]   V_ADDR,
  input  logic [LEN_W-1:0]  V_LEN,
  input  logic              V_ABORT,
  output logic [DW-1:0]     V_DATA,
  output logic              V_VALID,
  input  logic              V_READY,
  output logic              V_BUSY,
  output logic              V_DONE
);

  localparam int LANE_W = (VBYTES > 1) ? clog2(VBYTES) : 1;
  localparam int WORDS  = 2 ** VA_W;
  localparam int CNT_W  = clog2(FIFO_DEPTH) + 1;

  // CPU address split into word and byte lane
  logic [VA_W-1:0]   cpu_word;
  logic [LANE_W-1:0] cpu_lane;
  logic              cpu_wr;
  logic              cpu_rd;

  assign cpu_word = C_ADDR[ADDR_W-1 -: VA_W];
  assign cpu_wr   = C_CS && C_WE;
  assign cpu_rd   = C_CS && !C_WE;

  generate
    if (VBYTES > 1) begin : g_lane_sel
      assign cpu_lane = C_ADDR[LANE_W-1:0];
    end else begin : g_lane_one
      assign cpu_lane = '0;
    end
  endgenerate

  // Fetch engine state
  fsm_state_t        state_reg;
  fsm_state_t        state_next;
  logic [VA_W-1:0]   addr_reg;
  logic [VA_W-1:0]   addr_next;
  logic [LEN_W-1:0]  remain_reg;
  logic [LEN_W-1:0]  remain_next;
  logic              rd_valid_reg;
  logic              issue;
  logic              credit_ok;
  logic              final_pop;
  logic              fifo_flush;
  logic              fifo_pop;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DW-1:0]     vid_word;

  // CPU read-data path
  cdo_src_t          cdo_src_reg;
  logic [7:0]        wdata_reg;
  logic [LANE_W-1:0] lane_sel_reg;
  logic [7:0]        cpu_lane_q [VBYTES];

  // Memory is split into one byte-wide array per lane so CPU writes touch a single lane
  genvar gi;
  generate
    for (gi = 0; gi < VBYTES; gi++) begin : g_lane
      logic [7:0] lane_mem [WORDS];
      logic [7:0] cpu_q_reg;
      logic [7:0] vid_q_reg;
      logic       lane_wr;

      assign lane_wr = cpu_wr && (cpu_lane == LANE_W'(gi));

      // CPU write and CPU registered read of this lane
      always_ff @(posedge CLK) begin
        if (lane_wr) lane_mem[cpu_word] <= C_DI;
        if (cpu_rd)  cpu_q_reg <= lane_mem[cpu_word];
      end

      // Video registered read of this lane, captured on each issued fetch
      always_ff @(posedge CLK) begin
`ifdef AG_VRAM_COLLISION_BYPASS_EN
        if (issue) vid_q_reg <= (lane_wr && (cpu_word == addr_reg)) ? C_DI : lane_mem[addr_reg];
`else
        if (issue) vid_q_reg <= lane_mem[addr_reg];
`endif
      end

      assign vid_word[lane_offset(gi, VBYTES) +: 8] = vid_q_reg;
      assign cpu_lane_q[gi] = cpu_q_reg;
    end
  endgenerate

  // Track what C_DO should show: write data (write-first), read data, or zero after reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      cdo_src_reg  <= CDO_ZERO;
      wdata_reg    <= '0;
      lane_sel_reg <= '0;
    end else if (cpu_wr) begin
      cdo_src_reg <= CDO_WDATA;
      wdata_reg   <= C_DI;
    end else if (cpu_rd) begin
      cdo_src_reg  <= CDO_RDATA;
      lane_sel_reg <= cpu_lane;
    end
  end

  // Select the CPU read-data source
  always_comb begin
    C_DO = '0;
    case (cdo_src_reg)
      CDO_WDATA: C_DO = wdata_reg;
      CDO_RDATA: C_DO = cpu_lane_q[lane_sel_reg];
      default:   C_DO = '0;
    endcase
  end

  // Output FIFO between the memory read port and the video consumer
  ag_sync_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .FLUSH     (fifo_flush),
    .PUSH      (rd_valid_reg),
    .PUSH_DATA (vid_word),
    .POP       (fifo_pop),
    .POP_DATA  (V_DATA),
    .EMPTY     (fifo_empty),
    .COUNT     (fifo_count)
  );

  assign V_VALID   = !fifo_empty;
  assign fifo_pop  = V_READY && !fifo_empty;
  // Conservative credit: a same-cycle pop is not counted, so the FIFO can never overflow
  assign credit_ok = (int'(fifo_count) + int'(rd_valid_reg)) < FIFO_DEPTH;
  assign final_pop = (state_reg == DRAIN) && !rd_valid_reg &&
                     (fifo_count == CNT_W'(1)) && fifo_pop;

  // Fetch engine state register; the in-flight flag is dropped on abort
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      remain_reg   <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      remain_reg   <= remain_next;
      rd_valid_reg <= issue && !V_ABORT;
    end
  end

  // Fetch engine next-state logic; abort overrides everything
  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    remain_next = remain_reg;
    case (state_reg)
      IDLE: begin
        if (V_START && (V_LEN != '0)) begin
          state_next  = FETCH;
          addr_next   = V_ADDR;
          remain_next = V_LEN;
        end
      end
      FETCH: begin
        if (issue) begin
          addr_next   = addr_reg + VA_W'(1);
          remain_next = remain_reg - LEN_W'(1);
          if (remain_reg == LEN_W'(1)) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (final_pop) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (V_ABORT) state_next = IDLE;
  end

  // Fetch engine outputs
  always_comb begin
    issue      = (state_reg == FETCH) && credit_ok;
    V_BUSY     = (state_reg != IDLE);
    V_DONE     = final_pop && !V_ABORT;
    fifo_flush = V_ABORT;
  end

endmodule

// File: tb/tb_ag_vram_burst.sv
// Directed testbench for ag_vram_burst (default parameters).
module tb_ag_vram_burst;

  logic        CLK = 1'b0;
  logic        RST;
  logic        C_CS;
  logic        C_WE;
  logic [14:0] C_ADDR;
  logic [7:0]  C_DI;
  logic [7:0]  C_DO;
  logic        V_START;
  logic [13:0] V_ADDR;
  logic [6:0]  V_LEN;
  logic        V_ABORT;
  logic [15:0] V_DATA;
  logic        V_VALID;
  logic        V_READY;
  logic        V_BUSY;
  logic        V_DONE;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  logic [15:0] exp_q [$];

  always #5 CLK = ~CLK;

  ag_vram_burst dut (
    .CLK     (CLK),
    .RST     (RST),
    .C_CS    (C_CS),
    .C_WE    (C_WE),
    .C_ADDR  (C_ADDR),
    .C_DI    (C_DI),
    .C_DO    (C_DO),
    .V_START (V_START),
    .V_ADDR  (V_ADDR),
    .V_LEN   (V_LEN),
    .V_ABORT (V_ABORT),
    .V_DATA  (V_DATA),
    .V_VALID (V_VALID),
    .V_READY (V_READY),
    .V_BUSY  (V_BUSY),
    .V_DONE  (V_DONE)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic cpu_wr(input logic [14:0] addr, input logic [7:0] data);
    C_CS = 1'b1; C_WE = 1'b1; C_ADDR = addr; C_DI = data;
    cyc();
    C_CS = 1'b0; C_WE = 1'b0;
    chk("cpu_wr_first", C_DO, data);
  endtask

  task automatic cpu_rd(input logic [14:0] addr, input logic [7:0] exp);
    C_CS = 1'b1; C_WE = 1'b0; C_ADDR = addr;
    cyc();
    C_CS = 1'b0;
    chk("cpu_rd", C_DO, exp);
  endtask

  task automatic start_burst(input logic [13:0] addr, input logic [6:0] len);
    V_START = 1'b1; V_ADDR = addr; V_LEN = len;
    cyc();
    V_START = 1'b0; V_LEN = '0;
  endtask

  // mode 0: V_READY held high; mode 1: V_READY low for 10 cycles after the first word
  task automatic collect(input int len, input int mode, input int stop_after);
    int got = 0;
    int stall = 0;
    int spurious = 0;
    int overocc = 0;
    int first_c = -1;
    int last_c = -1;
    logic prev_hold = 1'b0;
    logic [15:0] prev_data = '0;
    for (int c = 0; c < 300 && got < stop_after; c++) begin
      V_READY = !(mode == 1 && got >= 1 && stall < 10);
      if (!V_READY && got >= 1) stall++;
      #1;
      if (prev_hold) begin
        chk("hold_valid", V_VALID, 1);
        chk("hold_data", V_DATA, prev_data);
      end
      if (int'(dut.fifo_count) > 4) overocc++;
      if (V_VALID && V_READY) begin
        chk("word", V_DATA, exp_q[got]);
        chk("done", V_DONE, got == len - 1);
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
      end else if (V_DONE) begin
        spurious++;
      end
      prev_hold = V_VALID && !V_READY;
      prev_data = V_DATA;
      cyc();
    end
    V_READY = 1'b0;
    chk("word_count", got, stop_after);
    chk("no_spurious_done", spurious, 0);
    chk("occ_le_depth", overocc, 0);
    if (mode == 0 && stop_after == len) chk("back_to_back", last_c - first_c, len - 1);
    if (stop_after == len) begin
      chk("busy_after", V_BUSY, 0);
      chk("valid_after", V_VALID, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; C_CS = 0; C_WE = 0; C_ADDR = 0; C_DI = 0;
    V_START = 0; V_ADDR = 0; V_LEN = 0; V_ABORT = 0; V_READY = 0;
    repeat (3) cyc();
    RST = 1'b0;
    chk("rst_c_do", C_DO, 0);
    chk("rst_valid", V_VALID, 0);
    chk("rst_busy", V_BUSY, 0);
    chk("rst_done", V_DONE, 0);

    // CPU write/read and lane mapping
    cpu_wr(15'h0000, 8'hA5);
    cpu_wr(15'h0001, 8'h3C);
    cpu_rd(15'h0000, 8'hA5);
    cpu_rd(15'h0001, 8'h3C);
    cyc();
    chk("cpu_idle_hold", C_DO, 8'h3C);
    exp_q = '{16'hA53C};
    start_burst(14'h0000, 7'd1);
    chk("busy_start", V_BUSY, 1);
    collect(1, 0, 1);

    // Preload words 0x10..0x17 with 0x1000+i
    for (int i = 0; i < 8; i++) begin
      cpu_wr(15'(16'h0020 + 2 * i), 8'h10);
      cpu_wr(15'(16'h0021 + 2 * i), 8'(i));
    end

    // Throughput
    exp_q = {};
    for (int i = 0; i < 8; i++) exp_q.push_back(16'(16'h1000 + i));
    start_burst(14'h0010, 7'd8);
    collect(8, 0, 8);

    // Backpressure
    start_burst(14'h0010, 7'd8);
    collect(8, 1, 8);

    // Address wrap past the top word
    cpu_wr(15'h7FFC, 8'hDE);
    cpu_wr(15'h7FFD, 8'hAD);
    cpu_wr(15'h7FFE, 8'hBE);
    cpu_wr(15'h7FFF, 8'hEF);
    cpu_wr(15'h0002, 8'h5A);
    cpu_wr(15'h0003, 8'hC3);
    exp_q = '{16'hDEAD, 16'hBEEF, 16'hA53C, 16'h5AC3};
    start_burst(14'h3FFE, 7'd4);
    collect(4, 0, 4);

    // Abort after three words
    exp_q = {};
    for (int i = 0; i < 8; i++) exp_q.push_back(16'(16'h1000 + i));
    start_burst(14'h0010, 7'd8);
    collect(8, 0, 3);
    V_ABORT = 1'b1;
    cyc();
    V_ABORT = 1'b0;
    chk("abort_valid", V_VALID, 0);
    chk("abort_busy", V_BUSY, 0);
    chk("abort_done", V_DONE, 0);
    V_READY = 1'b1;
    cyc();
    cyc();
    chk("abort_no_late_data", V_VALID, 0);
    V_READY = 1'b0;
    start_burst(14'h0010, 7'd0);
    chk("len0_busy", V_BUSY, 0);
    cyc();
    chk("len0_valid", V_VALID, 0);
    V_ABORT = 1'b1; V_START = 1'b1; V_ADDR = 14'h0010; V_LEN = 7'd4;
    cyc();
    V_ABORT = 1'b0; V_START = 1'b0; V_LEN = '0;
    chk("abort_beats_start", V_BUSY, 0);
    cyc();
    chk("abort_start_valid", V_VALID, 0);

    // Collision of CPU write and video read on word 0x20
    cpu_wr(15'h0040, 8'h12);
    cpu_wr(15'h0041, 8'h34);
`ifdef AG_VRAM_COLLISION_BYPASS_EN
    exp_q = '{16'h12FF};
`else
    exp_q = '{16'h1234};
`endif
    start_burst(14'h0020, 7'd1);
    cpu_wr(15'h0041, 8'hFF);
    collect(1, 0, 1);
    cpu_rd(15'h0041, 8'hFF);
    cpu_rd(15'h0040, 8'h12);

    // Reset mid-burst
    cpu_rd(15'h0000, 8'hA5);
    start_burst(14'h0010, 7'd8);
    cyc();
    cyc();
    cyc();
    chk("pre_rst_valid", V_VALID, 1);
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    chk("midrst_c_do", C_DO, 0);
    chk("midrst_valid", V_VALID, 0);
    chk("midrst_busy", V_BUSY, 0);
    cyc();
    chk("midrst_valid_after", V_VALID, 0);
    cpu_rd(15'h0000, 8'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
